// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: decodes one command onto the ALU control lines, holds the ALU inputs for SETTLE cycles,
// then returns the captured result and carry-out on a valid/ready response port.
module alu_cmd_sequencer #(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic             alu_op0,
    output logic             alu_op1,
    output logic             alu_op2,
    output logic             alu_cin,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_cout,
    output logic             rsp_err,
    output logic [CNT_W-1:0] ops_done
);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RESP} state_t;
    state_t           state_q;
    logic [3:0]       cnt_q;
    logic [3:0]       ctl_q;
    logic [3:0]       ctl_d;
    logic [WIDTH-1:0] alu_a_q, alu_b_q, rsp_data_q;
    logic             rsp_valid_q, rsp_cout_q, rsp_err_q;
    logic [CNT_W-1:0] ops_done_q;
    logic             legal;
    // ctl bit order is {op0, op1, op2, cin}
    always_comb begin
        legal = cmd_op <= 3'd4;
        ctl_d = (cmd_op == 3'd0) ? 4'b0000 :
                (cmd_op == 3'd1) ? 4'b1000 :
                (cmd_op == 3'd2) ? 4'b0100 :
                (cmd_op == 3'd3) ? 4'b0111 : 4'b1111;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ctl_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            ops_done_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (cmd_valid) begin
                    if (legal) begin
                        alu_a_q <= cmd_a;
                        alu_b_q <= cmd_b;
                        ctl_q   <= ctl_d;
                        cnt_q   <= 4'(SETTLE);
                        state_q <= S_SETTLE;
                    end else begin
                        rsp_data_q  <= '0;
                        rsp_cout_q  <= 1'b0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end
                S_SETTLE: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        rsp_data_q  <= alu_out;
                        rsp_cout_q  <= alu_cout;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                    if (!rsp_err_q) ops_done_q <= ops_done_q + 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
    assign cmd_ready = (state_q == S_IDLE) && !rst;
    assign {alu_op0, alu_op1, alu_op2, alu_cin} = ctl_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_err   = rsp_err_q;
    assign ops_done  = ops_done_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed and random commands against a command-level reference model,
// with a behavioural ALU attached to the sequencer's ALU port.
module tb_alu_cmd_sequencer;
    localparam int W  = 32;
    localparam int ST = 2;
    localparam int CW = 4;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready;
    logic [2:0]    cmd_op = '0;
    logic [W-1:0]  cmd_a = '0, cmd_b = '0;
    logic          alu_op0, alu_op1, alu_op2, alu_cin;
    logic [W-1:0]  alu_a, alu_b, alu_out;
    logic          alu_cout;
    logic          rsp_valid, rsp_ready = 1'b0;
    logic [W-1:0]  rsp_data;
    logic          rsp_cout, rsp_err;
    logic [CW-1:0] ops_done;
    always #5 clk = ~clk;
    alu_cmd_sequencer #(.WIDTH(W), .SETTLE(ST), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_op0(alu_op0), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_cin(alu_cin), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_cout(rsp_cout),
        .rsp_err(rsp_err), .ops_done(ops_done)
    );
    // Behavioural ALU driven by the control lines
    logic [W:0] s;
    always_comb begin
        s = {1'b0, alu_a} + {1'b0, alu_op2 ? ~alu_b : alu_b} + (W+1)'(alu_cin);
        alu_out  = 32'hDEADBEEF;
        alu_cout = 1'b0;
        case ({alu_op0, alu_op1, alu_op2, alu_cin})
            4'b0000: alu_out = alu_a & alu_b;
            4'b1000: alu_out = alu_a | alu_b;
            4'b0100, 4'b0111: begin alu_out = s[W-1:0]; alu_cout = s[W]; end
            4'b1111: begin alu_out = {31'b0, $signed(alu_a) < $signed(alu_b)}; alu_cout = s[W]; end
            default: ;
        endcase
    end
    int total = 0, bad = 0;
    int exp_done = 0;
    logic [W-1:0] last_a = '0, last_b = '0;
    logic [3:0]   last_ctl = '0;
    logic [3:0]   dec [8] = '{4'b0000, 4'b1000, 4'b0100, 4'b0111, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic void ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] r, output logic c, output logic e);
        e = op > 3'd4;
        c = 1'b0;
        r = '0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: {c, r} = {1'b0, a} + {1'b0, b};
            3'd3: begin r = a - b; c = a >= b; end
            3'd4: begin r = W'($signed(a) < $signed(b)); c = a >= b; end
            default: ;
        endcase
    endfunction
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        int n;
        logic [W-1:0] r;
        logic c, e;
        ref_op(op, a, b, r, c, e);
        n = 0;
        while (!cmd_ready && n < 50) begin step(); n++; end
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        step();
        // keep a stray command on the bus while busy; it must be ignored
        cmd_op = 3'($urandom); cmd_a = $urandom; cmd_b = $urandom;
        if (!e) begin last_a = a; last_b = b; last_ctl = dec[op]; end
        chk("alu_a", alu_a, last_a);
        chk("alu_b", alu_b, last_b);
        chk("alu_ctl", {alu_op0, alu_op1, alu_op2, alu_cin}, last_ctl);
        n = 0;
        while (!rsp_valid && n < 20) begin chk("cmd_ready_busy", cmd_ready, 0); step(); n++; end
        chk("latency", n, e ? 0 : ST);
        for (int i = 0; i <= hold; i++) begin
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_data", rsp_data, r);
            chk("rsp_cout", rsp_cout, c);
            chk("rsp_err", rsp_err, e);
            chk("cmd_ready_resp", cmd_ready, 0);
            chk("ops_done_hold", ops_done, exp_done);
            chk("alu_a_hold", alu_a, last_a);
            if (i == hold) begin rsp_ready = 1'b1; cmd_valid = 1'b0; end
            step();
        end
        rsp_ready = 1'b0;
        if (!e) exp_done = (exp_done + 1) % (1 << CW);
        chk("rsp_valid_clr", rsp_valid, 0);
        chk("ops_done", ops_done, exp_done);
        chk("cmd_ready_back", cmd_ready, 1);
    endtask
    initial begin
        step(); step();
        chk("rst_cmd_ready", cmd_ready, 0);
        rst = 1'b0;
        step();
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_ops_done", ops_done, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_ctl", {alu_op0, alu_op1, alu_op2, alu_cin}, 0);
        chk("rst_cmd_ready_rel", cmd_ready, 1);
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op(3'd3, 32'h0, 32'h1, 0);
        run_op(3'd4, 32'h0, 32'h1, 0);
        run_op(3'd0, 32'hFFFFFFFF, 32'h1, 5);
        run_op(3'd6, 32'h12345678, 32'h9ABCDEF0, 2);
        // reset in the middle of SETTLE discards the ADD
        cmd_valid = 1'b1; cmd_op = 3'd2; cmd_a = 32'h5; cmd_b = 32'h7;
        step();
        cmd_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        step();
        rst = 1'b0;
        step();
        chk("mid_rst_cmd_ready_rel", cmd_ready, 1);
        chk("mid_rst_ops_done", ops_done, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_b", alu_b, 0);
        for (int i = 0; i < 4; i++) begin chk("mid_rst_no_rsp", rsp_valid, 0); step(); end
        exp_done = 0; last_a = '0; last_b = '0; last_ctl = '0;
        for (int k = 0; k < 40; k++) begin
            logic [2:0] op;
            logic [W-1:0] a, b;
            op = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
            run_op(op, a, b, $urandom_range(0, 3));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
